// File: rtl/stream_fetch_reorder_if.sv
// ---------------------------------------------------------------------------
// stream_fetch_reorder_if
// Bundles every non-clock signal of the stream fetch/reorder engine.
//   Control : start, start_addr, start_len -> busy, done, err
//   Memory  : req, req_tag, req_addr <- req_stall ; push, push_tag, push_data
//   Consumer: out_valid, out_data, out_last <- out_stall
// The master modport is the fetch engine; slave is its environment
// (stream controller, memory and consumer seen as one).
// ---------------------------------------------------------------------------
interface stream_fetch_reorder_if #(
    parameter int ADDR_WIDTH = 48,
    parameter int DATA_WIDTH = 64,
    parameter int TAG_COUNT  = 4,
    parameter int TAG_WIDTH  = $clog2(TAG_COUNT),
    parameter int LEN_WIDTH  = 32
);
    logic                  start;
    logic [ADDR_WIDTH-1:0] start_addr;
    logic [LEN_WIDTH-1:0]  start_len;
    logic                  busy;
    logic                  done;
    logic                  req;
    logic                  req_stall;
    logic [TAG_WIDTH-1:0]  req_tag;
    logic [ADDR_WIDTH-1:0] req_addr;
    logic                  push;
    logic [TAG_WIDTH-1:0]  push_tag;
    logic [DATA_WIDTH-1:0] push_data;
    logic                  out_valid;
    logic                  out_stall;
    logic [DATA_WIDTH-1:0] out_data;
    logic                  out_last;
    logic                  err;

    modport master (
        input  start, start_addr, start_len, req_stall,
        input  push, push_tag, push_data, out_stall,
        output busy, done, req, req_tag, req_addr,
        output out_valid, out_data, out_last, err
    );

    modport slave (
        output start, start_addr, start_len, req_stall,
        output push, push_tag, push_data, out_stall,
        input  busy, done, req, req_tag, req_addr,
        input  out_valid, out_data, out_last, err
    );
endinterface

// File: rtl/stream_fetch_reorder.sv
// ---------------------------------------------------------------------------
// stream_fetch_reorder
// Streams a contiguous run of words from memory to a consumer. Up to
// TAG_COUNT word reads are outstanding at once, tagged round-robin; each tag
// is also the index of the reorder slot its response lands in, so responses
// may return in any order while the consumer sees words in address order.
// Ports:
//   clk  - clock
//   rst  - synchronous reset, active low
//   bus  - stream_fetch_reorder_if.master (control, memory and consumer sides)
// ---------------------------------------------------------------------------
module stream_fetch_reorder #(
    parameter int ADDR_WIDTH = 48,
    parameter int DATA_WIDTH = 64,
    parameter int TAG_COUNT  = 4,
    parameter int TAG_WIDTH  = $clog2(TAG_COUNT),
    parameter int LEN_WIDTH  = 32
) (
    input logic                   clk,
    input logic                   rst,
    stream_fetch_reorder_if.master bus
);

    localparam logic [ADDR_WIDTH-1:0] ADDR_STEP = ADDR_WIDTH'(DATA_WIDTH / 8);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t                state_q, state_d;
    logic [ADDR_WIDTH-1:0] req_addr_q, req_addr_d;
    logic [LEN_WIDTH-1:0]  len_q, len_d;
    logic [LEN_WIDTH-1:0]  issued_q, issued_d;
    logic [LEN_WIDTH-1:0]  sent_q, sent_d;
    logic [TAG_WIDTH-1:0]  issue_ptr_q, issue_ptr_d;
    logic [TAG_WIDTH-1:0]  read_ptr_q, read_ptr_d;
    logic [TAG_COUNT-1:0]  alloc_q, alloc_d;
    logic [TAG_COUNT-1:0]  filled_q, filled_d;
    logic                  err_q, err_d;
    logic [DATA_WIDTH-1:0] data_q [TAG_COUNT];

    logic issue;
    logic xfer;
    logic out_valid;
    logic last_word;
    logic push_ok;
    logic push_bad;

    // A slot stays allocated from issue until its word is consumed, so a
    // freed slot only becomes issuable on the following cycle. Pushes are
    // judged against the registered slot state: a push to a free slot or a
    // slot already holding data is a protocol error and its data is dropped.
    always_comb begin
        issue     = (state_q == RUN) && (issued_q < len_q) &&
                    !alloc_q[issue_ptr_q] && !bus.req_stall;
        out_valid = filled_q[read_ptr_q];
        last_word = (sent_q == len_q - LEN_WIDTH'(1));
        xfer      = out_valid && !bus.out_stall;
        push_ok   = bus.push && alloc_q[bus.push_tag] && !filled_q[bus.push_tag];
        push_bad  = bus.push && !push_ok;
    end

    // Next-state logic. Issue, response and transfer all touch the slot
    // vectors independently; the start branch runs last so an accepted start
    // rewinds pointers and counters and wins over a same-cycle bad push.
    always_comb begin
        state_d     = state_q;
        req_addr_d  = req_addr_q;
        len_d       = len_q;
        issued_d    = issued_q;
        sent_d      = sent_q;
        issue_ptr_d = issue_ptr_q;
        read_ptr_d  = read_ptr_q;
        alloc_d     = alloc_q;
        filled_d    = filled_q;
        err_d       = err_q;

        if (issue) begin
            alloc_d[issue_ptr_q] = 1'b1;
            issue_ptr_d          = issue_ptr_q + TAG_WIDTH'(1);
            issued_d             = issued_q + LEN_WIDTH'(1);
            req_addr_d           = req_addr_q + ADDR_STEP;
        end

        if (push_ok) begin
            filled_d[bus.push_tag] = 1'b1;
        end

        if (xfer) begin
            alloc_d[read_ptr_q]  = 1'b0;
            filled_d[read_ptr_q] = 1'b0;
            read_ptr_d           = read_ptr_q + TAG_WIDTH'(1);
            sent_d               = sent_q + LEN_WIDTH'(1);
        end

        if (push_bad) begin
            err_d = 1'b1;
        end

        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    req_addr_d  = bus.start_addr;
                    len_d       = bus.start_len;
                    issued_d    = '0;
                    sent_d      = '0;
                    issue_ptr_d = '0;
                    read_ptr_d  = '0;
                    err_d       = 1'b0;
                    state_d     = (bus.start_len == '0) ? DONE : RUN;
                end
            end
            RUN: begin
                if (xfer && last_word) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State registers; reset abandons any stream in flight and frees all
    // slots, so late responses for old tags are flagged as errors.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= IDLE;
            req_addr_q  <= '0;
            len_q       <= '0;
            issued_q    <= '0;
            sent_q      <= '0;
            issue_ptr_q <= '0;
            read_ptr_q  <= '0;
            alloc_q     <= '0;
            filled_q    <= '0;
            err_q       <= 1'b0;
            for (int i = 0; i < TAG_COUNT; i++) begin
                data_q[i] <= '0;
            end
        end else begin
            state_q     <= state_d;
            req_addr_q  <= req_addr_d;
            len_q       <= len_d;
            issued_q    <= issued_d;
            sent_q      <= sent_d;
            issue_ptr_q <= issue_ptr_d;
            read_ptr_q  <= read_ptr_d;
            alloc_q     <= alloc_d;
            filled_q    <= filled_d;
            err_q       <= err_d;
            if (push_ok) begin
                data_q[bus.push_tag] <= bus.push_data;
            end
        end
    end

    assign bus.req       = issue;
    assign bus.req_tag   = issue_ptr_q;
    assign bus.req_addr  = req_addr_q;
    assign bus.out_valid = out_valid;
    assign bus.out_data  = data_q[read_ptr_q];
    assign bus.out_last  = out_valid && last_word;
    assign bus.busy      = (state_q == RUN);
    assign bus.done      = (state_q == DONE);
    assign bus.err       = err_q;

endmodule
